// File: rtl/thunderbird_seq.sv
// Turn-signal sequencer: LAMPS-wide thermometer lamps per side, step prescaler, hazard preemption.
// Optional THUNDERBIRD_HAZARD_EN adds a dedicated hazard input OR'd with (left & right).
module thunderbird_seq #(
  parameter int unsigned LAMPS = 3,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
`ifdef THUNDERBIRD_HAZARD_EN
  input  logic             hazard,
`endif
  output logic [LAMPS-1:0] la,
  output logic [LAMPS-1:0] ra,
  output logic             busy
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW = $clog2(LAMPS + 1);

  // Sequence direction plus a separate step index stands in for L1..Ln / R1..Rn
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LSEQ = 2'd1,
    RSEQ = 2'd2,
    HAZ  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [SW-1:0]   step;
  logic [SW-1:0]   step_d;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic            hz;
  logic [LAMPS-1:0] therm;
  logic [LAMPS-1:0] la_d;
  logic [LAMPS-1:0] ra_d;
  logic            busy_d;

  assign tick = (cnt == CW'(DIV - 1));

`ifdef THUNDERBIRD_HAZARD_EN
  assign hz = (left & right) | hazard;
`else
  assign hz = left & right;
`endif

  // Prescaler, state and registered lamp outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      state <= IDLE;
      step  <= '0;
      la    <= '0;
      ra    <= '0;
      busy  <= 1'b0;
    end else begin
      cnt   <= tick ? '0 : cnt + CW'(1);
      state <= state_d;
      step  <= step_d;
      la    <= la_d;
      ra    <= ra_d;
      busy  <= busy_d;
    end
  end

  // Next state and the lamp pattern that state will display
  always_comb begin
    state_d = state;
    step_d  = step;
    therm   = '0;
    la_d    = '0;
    ra_d    = '0;
    busy_d  = 1'b0;

    if (tick) begin
      unique case (state)
        IDLE: begin
          if (hz) begin
            state_d = HAZ;
            step_d  = '0;
          end else if (left) begin
            state_d = LSEQ;
            step_d  = SW'(1);
          end else if (right) begin
            state_d = RSEQ;
            step_d  = SW'(1);
          end
        end
        LSEQ, RSEQ: begin
          if (hz) begin
            state_d = HAZ;
            step_d  = '0;
          end else if (step < SW'(LAMPS)) begin
            step_d = step + SW'(1);
          end else begin
            state_d = IDLE;
            step_d  = '0;
          end
        end
        HAZ: begin
          state_d = IDLE;
          step_d  = '0;
        end
        default: begin
          state_d = IDLE;
          step_d  = '0;
        end
      endcase
    end

    for (int unsigned i = 0; i < LAMPS; i++) begin
      therm[i] = (SW'(i) < step_d);
    end

    unique case (state_d)
      LSEQ:    la_d = therm;
      RSEQ:    ra_d = therm;
      HAZ: begin
        la_d = '1;
        ra_d = '1;
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_thunderbird_seq.sv
// Scoreboard bench for thunderbird_seq: two instances (3 lamps/DIV 1 and 5 lamps/DIV 4) on shared inputs.
module tb_thunderbird_seq;

`ifdef THUNDERBIRD_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  localparam int NL_A  = 3;
  localparam int DIV_A = 1;
  localparam int NL_B  = 5;
  localparam int DIV_B = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic left = 1'b0;
  logic right = 1'b0;
  logic hazard = 1'b0;

  logic [NL_A-1:0] la_a, ra_a;
  logic [NL_B-1:0] la_b, ra_b;
  logic            busy_a, busy_b;

  always #5 clk = ~clk;

  thunderbird_seq #(.LAMPS(NL_A), .DIV(DIV_A)) dut_a (
    .clk(clk), .reset(reset), .left(left), .right(right),
`ifdef THUNDERBIRD_HAZARD_EN
    .hazard(hazard),
`endif
    .la(la_a), .ra(ra_a), .busy(busy_a)
  );

  thunderbird_seq #(.LAMPS(NL_B), .DIV(DIV_B)) dut_b (
    .clk(clk), .reset(reset), .left(left), .right(right),
`ifdef THUNDERBIRD_HAZARD_EN
    .hazard(hazard),
`endif
    .la(la_b), .ra(ra_b), .busy(busy_b)
  );

  typedef struct {
    int unsigned la[2];
    int unsigned ra[2];
    int unsigned busy[2];
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: cycles since reset, signed lamp position (+k left, -k right), hazard flag
  int cyc[2];
  int pos[2];
  bit hon[2];

  function automatic void model_edge(int d, int nl, int div, bit r, bit l, bit rt, bit h);
    bit tk;
    bit hzv;
    if (!r) begin
      cyc[d] = 0;
      pos[d] = 0;
      hon[d] = 1'b0;
      return;
    end
    tk = ((cyc[d] % div) == div - 1);
    cyc[d]++;
    if (!tk) return;
    hzv = (l & rt) | (HAZ_EN & h);
    if (hon[d]) begin
      hon[d] = 1'b0;
    end else if (hzv) begin
      hon[d] = 1'b1;
      pos[d] = 0;
    end else if (pos[d] == 0) begin
      pos[d] = l ? 1 : (rt ? -1 : 0);
    end else if (pos[d] > 0) begin
      pos[d] = (pos[d] < nl) ? pos[d] + 1 : 0;
    end else begin
      pos[d] = (-pos[d] < nl) ? pos[d] - 1 : 0;
    end
  endfunction

  function automatic int unsigned lamps(int nl, int k);
    return (k <= 0) ? 0 : ((1 << k) - 1) & ((1 << nl) - 1);
  endfunction

  function automatic void fill(int d, int nl, ref exp_t e);
    int unsigned all = (1 << nl) - 1;
    e.la[d]   = hon[d] ? all : lamps(nl, pos[d]);
    e.ra[d]   = hon[d] ? all : lamps(nl, -pos[d]);
    e.busy[d] = (hon[d] || pos[d] != 0) ? 1 : 0;
  endfunction

  task automatic cycle(bit r, bit l, bit rt, bit h);
    exp_t e;
    reset  = r;
    left   = l;
    right  = rt;
    hazard = h;
    @(posedge clk);
    model_edge(0, NL_A, DIV_A, r, l, rt, h);
    model_edge(1, NL_B, DIV_B, r, l, rt, h);
    fill(0, NL_A, e);
    fill(1, NL_B, e);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic hold(bit r, bit l, bit rt, bit h, int n);
    for (int i = 0; i < n; i++) cycle(r, l, rt, h);
  endtask

  function automatic void chk(string name, int unsigned act, int unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: every edge produces one output sample, compared away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("la_a",   32'(la_a),   e.la[0]);
        chk("ra_a",   32'(ra_a),   e.ra[0]);
        chk("busy_a", 32'(busy_a), e.busy[0]);
        chk("la_b",   32'(la_b),   e.la[1]);
        chk("ra_b",   32'(ra_b),   e.ra[1]);
        chk("busy_b", 32'(busy_b), e.busy[1]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit r, l, rt, h;
    // reset, then a held left turn (covers the 5-lamp DIV 4 cadence too)
    hold(1'b0, 1'b0, 1'b0, 1'b0, 2);
    hold(1'b1, 1'b1, 1'b0, 1'b0, 26);
    hold(1'b1, 1'b0, 1'b0, 1'b0, 8);
    // single-cycle right request
    hold(1'b0, 1'b0, 1'b0, 1'b0, 1);
    hold(1'b1, 1'b0, 1'b1, 1'b0, 1);
    hold(1'b1, 1'b0, 1'b0, 1'b0, 8);
    // left and right together flash hazard; then mid-sequence preemption
    hold(1'b1, 1'b1, 1'b1, 1'b0, 12);
    hold(1'b1, 1'b0, 1'b0, 1'b0, 4);
    hold(1'b1, 1'b1, 1'b0, 1'b0, 6);
    hold(1'b1, 1'b1, 1'b1, 1'b0, 3);
    hold(1'b1, 1'b0, 1'b0, 1'b0, 6);
    // dedicated hazard input while a left sequence runs
    hold(1'b1, 1'b1, 1'b0, 1'b0, 2);
    hold(1'b1, 1'b1, 1'b0, 1'b1, 10);
    hold(1'b1, 1'b0, 1'b0, 1'b0, 6);
    // reset mid-sequence, then restart
    hold(1'b1, 1'b1, 1'b0, 1'b0, 2);
    hold(1'b0, 1'b1, 1'b0, 1'b0, 1);
    hold(1'b1, 1'b1, 1'b0, 1'b0, 12);
    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 59) != 0);
      l  = ($urandom_range(0, 2) == 0);
      rt = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 7) == 0);
      hold(r, l, rt, h, $urandom_range(1, 6));
    end
    hold(1'b1, 1'b0, 1'b0, 1'b0, 4);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected samples never compared", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thunderbird_seq.md
# thunderbird_seq

Parametrised turn-signal sequencer: the next generation of the fixed three-lamp-per-side lab controller, generalised to LAMPS lamps per side with a built-in step prescaler, mid-sequence hazard preemption and a busy flag. It sits between the board wrapper's switch/key inputs and the red/green LED banks, driving both lamp banks as thermometer codes. All outputs are registered (Moore).

## Interface
- LAMPS, default 3: lamps per side; legal range 2..16.
- DIV, default 1: clock cycles per sequencer step; legal range 1..2^24.
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-low (0 = reset), sampled on rising clk.
- left  input  1  left-turn request, level-sensitive.
- right  input  1  right-turn request, level-sensitive.
- hazard  input  1  hazard request, level-sensitive; present only when THUNDERBIRD_HAZARD_EN is defined.
- la  output  LAMPS  left lamps; bit 0 innermost.
- ra  output  LAMPS  right lamps; bit 0 innermost.
- busy  output  1  high whenever state is not IDLE.

## Operation
- Prescaler: counter of width max(1, clog2(DIV)), free-running from reset, counts 0..DIV-1 and wraps; `tick` = (count == DIV-1). With DIV=1, `tick` is high every cycle.
- State register changes only on cycles where `tick` is high; inputs are sampled only on those cycles.
- States: IDLE, L[1..LAMPS], R[1..LAMPS], HAZ.
- Hazard condition `hz` = (left & right), OR'd with `hazard` when the macro is enabled.
- IDLE, on tick: hz -> HAZ; else left -> L1; else right -> R1; else IDLE. Priority is hz > left > right.
- L[k], on tick: hz -> HAZ (preempt); else k<LAMPS -> L[k+1]; else IDLE. The sequence runs to completion even if `left` drops.
- R[k]: mirror of L[k].
- HAZ, on tick: always -> IDLE. This gives a dark step, then IDLE resamples, so a held hazard flashes 1 tick on, 1 tick off.
- Outputs:
  - L[k]: la = low k bits set, ra = 0.
  - R[k]: ra = low k bits set, la = 0.
  - HAZ: la = ra = all ones.
  - IDLE: both 0.
- Turn-signal period is LAMPS+1 ticks (LAMPS lit steps plus one dark IDLE step).

## Timing
- Reset (reset=0 at a rising edge): state IDLE, prescaler 0, la=0, ra=0, busy=0 after that edge.
- Reset asserted mid-sequence or mid-HAZ: all outputs 0 after the same edge.
- Prescaler restarts at 0 when reset is released, so the first `tick` falls DIV-1 cycles after the first non-reset edge.
- Latency: a request held across a tick edge in IDLE shows on the lamps immediately after that edge. There is no combinational path from inputs to outputs.
- Requests that rise and fall entirely between ticks are ignored; there is no latching.
- left and right both high without hazard resolves to HAZ, never to a one-sided sequence.
- `busy` changes on the same edge as the lamps.

## Configuration
- THUNDERBIRD_HAZARD_EN defined: the `hazard` port exists and is OR'd into `hz`.
- THUNDERBIRD_HAZARD_EN undefined: no `hazard` port; `hz` = left & right only. HAZ state, mid-sequence preemption and the state encoding are otherwise unchanged.

## Test plan
- LAMPS=3, DIV=1; reset=0 for 2 cycles, then left=1 held -> la sequence 001, 011, 111, 000, 001 on consecutive cycles; ra=0 throughout; busy = 1,1,1,0,1.
- LAMPS=3, DIV=1; right=1 for one cycle only -> ra 001, 011, 111, 000, then stays 000.
- LAMPS=3, DIV=1, macro on; left held, then hazard=1 asserted while la=011 -> next cycle la=ra=111, then 000/000, then 111/111 while hazard is held.
- LAMPS=3, DIV=1, macro off; left=right=1 -> outputs alternate 111/111 and 000/000 each cycle.
- LAMPS=5, DIV=4; left held after reset release -> la changes only every 4th cycle: 00001 at cycle 4, 00011 at cycle 8, ... 11111 at cycle 20, 00000 at cycle 24.
- LAMPS=3, DIV=1; reset=0 while la=011 -> la=ra=0 and busy=0 after that edge; after release with left=1, la=001 on the next edge.
